// File: rtl/vga_pkg.sv
// vga_pkg: pattern mode encodings, 3-bit {r,g,b} colour constants and standard timing presets
package vga_pkg;
    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_GRID    = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;
    localparam logic [2:0] RGB_BLACK   = 3'b000;
    localparam logic [2:0] RGB_BLUE    = 3'b001;
    localparam logic [2:0] RGB_GREEN   = 3'b010;
    localparam logic [2:0] RGB_CYAN    = 3'b011;
    localparam logic [2:0] RGB_RED     = 3'b100;
    localparam logic [2:0] RGB_MAGENTA = 3'b101;
    localparam logic [2:0] RGB_YELLOW  = 3'b110;
    localparam logic [2:0] RGB_WHITE   = 3'b111;
    typedef struct packed {
        logic [11:0] sync;
        logic [11:0] back;
        logic [11:0] active;
        logic [11:0] front;
    } axis_t;
    localparam axis_t H_800X600_72   = '{12'd120, 12'd64, 12'd800, 12'd56};
    localparam axis_t V_800X600_72   = '{12'd6, 12'd23, 12'd600, 12'd37};
    localparam axis_t H_1280X1024_60 = '{12'd112, 12'd248, 12'd1280, 12'd48};
    localparam axis_t V_1280X1024_60 = '{12'd3, 12'd38, 12'd1024, 12'd1};
endpackage

// File: rtl/vga_timing_pattern_if.sv
// vga_timing_pattern_if: pattern request in, registered raster/video signals out
interface vga_timing_pattern_if #(parameter int COLOR_BITS = 1);
    logic [1:0]            mode_sel;
    logic                  hsync;
    logic                  vsync;
    logic                  de;
    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] green;
    logic [COLOR_BITS-1:0] blue;
    logic [11:0]           x_pos;
    logic [11:0]           y_pos;
    logic                  frame_start;
    logic [1:0]            mode_active;
    modport master (input mode_sel, output hsync, vsync, de, red, green, blue, x_pos, y_pos, frame_start, mode_active);
    modport slave (output mode_sel, input hsync, vsync, de, red, green, blue, x_pos, y_pos, frame_start, mode_active);
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: combinational test-pattern colour for one active-area pixel
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 1024,
    parameter int COLOR_BITS = 1,
    parameter int CHECK_LOG2 = 5,
    parameter int GRID_LOG2  = 6,
    parameter int BLINK_LOG2 = 5
) (
    input  mode_e                 mode_i,
    input  logic [11:0]           x_i,
    input  logic [11:0]           y_i,
    input  logic [7:0]            frame_cnt_i,
    input  logic                  in_active_i,
    output logic [COLOR_BITS-1:0] red_o,
    output logic [COLOR_BITS-1:0] green_o,
    output logic [COLOR_BITS-1:0] blue_o
);
    logic [2:0] bar_idx, bar_rgb, blink_rgb, rgb;
    logic       grid_on;
    assign blink_rgb = ((frame_cnt_i >> BLINK_LOG2) & 8'd1) != 8'd0 ? RGB_BLACK : RGB_WHITE;
    assign grid_on = x_i[GRID_LOG2-1:0] == '0 || y_i[GRID_LOG2-1:0] == '0 ||
                     x_i == 12'(H_ACTIVE-1) || y_i == 12'(V_ACTIVE-1);
    // boundaries are increasing, so the last one passed is the bar index
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++)
            if (x_i >= 12'(k * H_ACTIVE / 8)) bar_idx = 3'(k);
    end
    always_comb begin
        case (bar_idx)
            3'd0:    bar_rgb = blink_rgb;
            3'd1:    bar_rgb = RGB_YELLOW;
            3'd2:    bar_rgb = RGB_CYAN;
            3'd3:    bar_rgb = RGB_GREEN;
            3'd4:    bar_rgb = RGB_MAGENTA;
            3'd5:    bar_rgb = RGB_RED;
            3'd6:    bar_rgb = RGB_BLUE;
            default: bar_rgb = RGB_WHITE;
        endcase
    end
    always_comb begin
        case (mode_i)
            MODE_BARS:    rgb = y_i >= 12'(V_ACTIVE/4) ? RGB_GREEN : bar_rgb;
            MODE_CHECKER: rgb = (x_i[CHECK_LOG2] ^ y_i[CHECK_LOG2]) ? RGB_BLACK : RGB_WHITE;
            MODE_GRID:    rgb = grid_on ? RGB_WHITE : RGB_BLACK;
            default:      rgb = blink_rgb;
        endcase
        if (!in_active_i) rgb = RGB_BLACK;
    end
    assign red_o   = {COLOR_BITS{rgb[2]}};
    assign green_o = {COLOR_BITS{rgb[1]}};
    assign blue_o  = {COLOR_BITS{rgb[0]}};
endmodule

// File: rtl/vga_timing_pattern.sv
// vga_timing_pattern: H/V raster counters (stage 0) feeding one register stage of syncs, DE,
// coordinates and test-pattern colour (stage 1), so every pin has the same 1-clk latency.
module vga_timing_pattern
    import vga_pkg::*;
#(
    parameter int H_SYNC     = 112,
    parameter int H_BACK     = 248,
    parameter int H_ACTIVE   = 1280,
    parameter int H_FRONT    = 48,
    parameter int V_SYNC     = 3,
    parameter int V_BACK     = 38,
    parameter int V_ACTIVE   = 1024,
    parameter int V_FRONT    = 1,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int COLOR_BITS = 1,
    parameter int CHECK_LOG2 = 5,
    parameter int GRID_LOG2  = 6,
    parameter int BLINK_LOG2 = 5
) (
    input logic clk,
    input logic rst,
    vga_timing_pattern_if.master vga
);
    localparam int          H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int          V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam logic [11:0] H_ACT0  = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_ACTL  = 12'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [11:0] V_ACT0  = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_ACTL  = 12'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic        HP      = 1'(H_SYNC_POL);
    localparam logic        VP      = 1'(V_SYNC_POL);
    logic [11:0]           h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
    logic [7:0]            fc_q, fc_d;
    logic                  run_q, h_end, v_end;
    logic                  hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    mode_e                 mode_q, mode_d;
    // run_q holds the counters at 0,0 for the first clk after reset release
    always_comb begin
        h_end  = h_q == 12'(H_TOTAL - 1);
        v_end  = v_q == 12'(V_TOTAL - 1);
        h_d    = !run_q ? h_q : h_end ? '0 : h_q + 12'd1;
        v_d    = !(run_q && h_end) ? v_q : v_end ? '0 : v_q + 12'd1;
        fc_d   = run_q && h_end && v_end ? fc_q + 8'd1 : fc_q;
        fs_d   = run_q && h_q == '0 && v_q == '0;
        mode_d = fs_d ? mode_e'(vga.mode_sel) : mode_q;
        hs_d   = run_q && h_q < 12'(H_SYNC) ? HP : !HP;
        vs_d   = run_q && v_q < 12'(V_SYNC) ? VP : !VP;
        de_d   = run_q && h_q >= H_ACT0 && h_q <= H_ACTL && v_q >= V_ACT0 && v_q <= V_ACTL;
        x_d    = de_d ? h_q - H_ACT0 : '0;
        y_d    = de_d ? v_q - V_ACT0 : '0;
    end
    vga_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .COLOR_BITS(COLOR_BITS),
        .CHECK_LOG2(CHECK_LOG2), .GRID_LOG2(GRID_LOG2), .BLINK_LOG2(BLINK_LOG2)
    ) u_gen (
        .mode_i(mode_d), .x_i(x_d), .y_i(y_d), .frame_cnt_i(fc_q), .in_active_i(de_d),
        .red_o(r_d), .green_o(g_d), .blue_o(b_d)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            fc_q   <= '0;
            mode_q <= MODE_BARS;
            hs_q   <= !HP;
            vs_q   <= !VP;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            run_q  <= 1'b1;
            h_q    <= h_d;
            v_q    <= v_d;
            fc_q   <= fc_d;
            mode_q <= mode_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            fs_q   <= fs_d;
            x_q    <= x_d;
            y_q    <= y_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.de          = de_q;
    assign vga.frame_start = fs_q;
    assign vga.x_pos       = x_q;
    assign vga.y_pos       = y_q;
    assign vga.red         = r_q;
    assign vga.green       = g_q;
    assign vga.blue        = b_q;
    assign vga.mode_active = mode_q;
endmodule

// File: tb/tb_vga_timing_pattern.sv
// tb_vga_timing_pattern: small-raster bench (H 4/4/16/4, V 2/2/8/1, 2-bit colour) with a
// per-cycle raster model, a hand-computed pixel table and directed mode/reset sequences.
module tb_vga_timing_pattern;
    localparam int HT = 28;
    localparam int VT = 13;
    localparam int FT = HT * VT;
    typedef struct {
        int          mode;
        int          h;
        int          v;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic [5:0]  rgb;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n = -2;
    vec_t vecs[15];
    logic [5:0] blink_exp[6];
    always #5 clk = ~clk;
    vga_timing_pattern_if #(.COLOR_BITS(2)) vif ();
    vga_timing_pattern_if #(.COLOR_BITS(2)) vif2 ();
    assign vif2.mode_sel = 2'd0;
    vga_timing_pattern #(
        .H_SYNC(4), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(8), .V_FRONT(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .COLOR_BITS(2),
        .CHECK_LOG2(2), .GRID_LOG2(2), .BLINK_LOG2(1)
    ) dut (.clk(clk), .rst(rst), .vga(vif.master));
    vga_timing_pattern #(
        .H_SYNC(4), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(8), .V_FRONT(1),
        .H_SYNC_POL(0), .V_SYNC_POL(1), .COLOR_BITS(2),
        .CHECK_LOG2(2), .GRID_LOG2(2), .BLINK_LOG2(1)
    ) dut2 (.clk(clk), .rst(rst), .vga(vif2.master));

    function automatic logic [2:0] blink3(int f);
        return ((f >> 1) & 1) != 0 ? 3'b000 : 3'b111;
    endfunction
    function automatic logic [5:0] dbl(logic [2:0] c);
        return {c[2], c[2], c[1], c[1], c[0], c[0]};
    endfunction
    function automatic logic [5:0] model_rgb(int mode, int x, int y, int f);
        logic [2:0] bars[8];
        bars = '{blink3(f), 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b111};
        case (mode)
            0: return dbl(y >= 2 ? 3'b010 : bars[x / 2]);
            1: return dbl((((x >> 2) ^ (y >> 2)) & 1) != 0 ? 3'b000 : 3'b111);
            2: return dbl((x % 4 == 0 || y % 4 == 0 || x == 15 || y == 7) ? 3'b111 : 3'b000);
            default: return dbl(blink3(f));
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask
    task automatic goto(int h, int v);
        int guard = 0;
        do begin
            tick();
            guard++;
        end while (!(n >= 0 && n % HT == h && (n / HT) % VT == v) && guard < 2 * FT);
        if (guard >= 2 * FT) check("goto_budget", 64'(guard), 64'(0));
    endtask
    task automatic check_reset(string name);
        check(name, 64'({vif.hsync, vif.vsync, vif.de, vif.frame_start, vif.x_pos, vif.y_pos,
                          vif.red, vif.green, vif.blue, vif.mode_active}), 64'(0));
        check({name, "_pol"}, 64'({vif2.hsync, vif2.vsync}), 64'(2'b10));
    endtask
    task automatic check_raster(int mode);
        int h = n % HT;
        int v = (n / HT) % VT;
        logic d = h >= 8 && h < 24 && v >= 4 && v < 12;
        logic [37:0] exp;
        exp = {h < 4, v < 2, d, h == 0 && v == 0, d ? 12'(h - 8) : 12'd0, d ? 12'(v - 4) : 12'd0,
               d ? model_rgb(mode, h - 8, v - 4, n / FT) : 6'd0};
        check("raster", 64'({vif.hsync, vif.vsync, vif.de, vif.frame_start, vif.x_pos, vif.y_pos,
                             vif.red, vif.green, vif.blue}), 64'(exp));
        check("raster_pol", 64'({vif2.hsync, vif2.vsync}), 64'({h >= 4, v < 2}));
    endtask

    initial begin
        int shown;
        vecs = '{
            '{0, 5, 4, 1'b0, 12'd0, 12'd0, 6'b000000},
            '{0, 10, 4, 1'b1, 12'd2, 12'd0, 6'b111100},
            '{0, 21, 4, 1'b1, 12'd13, 12'd0, 6'b000011},
            '{0, 18, 5, 1'b1, 12'd10, 12'd1, 6'b110000},
            '{0, 23, 5, 1'b1, 12'd15, 12'd1, 6'b111111},
            '{0, 12, 6, 1'b1, 12'd4, 12'd2, 6'b001100},
            '{0, 20, 11, 1'b1, 12'd12, 12'd7, 6'b001100},
            '{0, 20, 12, 1'b0, 12'd0, 12'd0, 6'b000000},
            '{1, 8, 4, 1'b1, 12'd0, 12'd0, 6'b111111},
            '{1, 12, 4, 1'b1, 12'd4, 12'd0, 6'b000000},
            '{1, 12, 8, 1'b1, 12'd4, 12'd4, 6'b111111},
            '{2, 9, 5, 1'b1, 12'd1, 12'd1, 6'b000000},
            '{2, 23, 5, 1'b1, 12'd15, 12'd1, 6'b111111},
            '{2, 14, 9, 1'b1, 12'd6, 12'd5, 6'b000000},
            '{2, 13, 11, 1'b1, 12'd5, 12'd7, 6'b111111}
        };
        blink_exp = '{6'h3f, 6'h3f, 6'h00, 6'h00, 6'h3f, 6'h3f};
        vif.mode_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b1;
        n = -2;
        tick();
        check("first_clk", 64'({vif.frame_start, vif.de, vif.hsync}), 64'(0));
        tick();
        check_raster(0);
        for (int i = 1; i < 2 * FT; i++) begin
            tick();
            check_raster(0);
        end
        shown = 0;
        foreach (vecs[i]) begin
            if (vecs[i].mode != shown) begin
                vif.mode_sel = 2'(vecs[i].mode);
                goto(0, 0);
                shown = vecs[i].mode;
                check("mode_latch", 64'(vif.mode_active), 64'(vecs[i].mode));
            end
            goto(vecs[i].h, vecs[i].v);
            check($sformatf("vec%0d", i), 64'({vif.de, vif.x_pos, vif.y_pos, vif.red, vif.green, vif.blue}),
                  64'({vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].rgb}));
        end
        vif.mode_sel = 2'd0;
        goto(0, 0);
        goto(0, 5);
        vif.mode_sel = 2'd1;
        goto(14, 5);
        check("midframe_hold", 64'({vif.mode_active, vif.red, vif.green, vif.blue}), 64'({2'd0, 6'b001100}));
        goto(0, 0);
        check("next_frame_mode", 64'({vif.frame_start, vif.mode_active}), 64'({1'b1, 2'd1}));
        goto(14, 5);
        check("checker_px", 64'({vif.red, vif.green, vif.blue}), 64'(6'b000000));
        goto(27, 12);
        vif.mode_sel = 2'd2;
        tick();
        check("fs_same_clk", 64'({vif.frame_start, vif.mode_active}), 64'({1'b1, 2'd2}));
        goto(9, 5);
        check("grid_px", 64'({vif.red, vif.green, vif.blue}), 64'(6'b000000));
        goto(20, 6);
        rst = 1'b0;
        #1;
        check_reset("async_reset");
        vif.mode_sel = 2'd3;
        tick();
        check_reset("reset_hold");
        @(negedge clk);
        rst = 1'b1;
        n = -2;
        tick();
        check("restart_first_clk", 64'({vif.frame_start, vif.de}), 64'(0));
        tick();
        check("restart_fs", 64'({vif.frame_start, vif.mode_active}), 64'({1'b1, 2'd3}));
        goto(8, 4);
        check("restart_first_de", 64'({vif.de, vif.x_pos, vif.y_pos}), 64'({1'b1, 24'd0}));
        for (int f = 0; f < 6; f++) begin
            goto(12, 6);
            check($sformatf("blink_f%0d", f), 64'({vif.red, vif.green, vif.blue}), 64'(blink_exp[f]));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
